// File: rtl/dcache_arb_pkg.sv
// -----------------------------------------------------------------------------
// dcache_arb_pkg
// Shared types for the data-cache port arbiter:
//   arb_state_e  - arbiter FSM states (free arbitration / locked DMA burst)
//   port_id_e    - requester identity (CPU MEM stage, DMA/debug loader)
//   resp_t       - registered response {valid, err, data} returned to a port
// -----------------------------------------------------------------------------
package dcache_arb_pkg;

    // Width of the response data field; matches the arbiter's default DATA_W.
    localparam int RESP_DATA_W = 32;

    typedef enum logic {
        ARB      = 1'b0,
        DMA_LOCK = 1'b1
    } arb_state_e;

    typedef enum logic {
        PORT_CPU = 1'b0,
        PORT_DMA = 1'b1
    } port_id_e;

    typedef struct packed {
        logic                   valid;
        logic                   err;
        logic [RESP_DATA_W-1:0] data;
    } resp_t;

endpackage

// File: rtl/dcache_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// dcache_port_arbiter_if
// Bundles both requester ports and the single-port cache strobes.
//   cpu_* : CPU MEM stage request / grant / response
//   dma_* : DMA/debug loader request (plus burst length) / grant / response
//   cache_*: address, strobes and write data to the cache, read data back
// Modports:
//   master - requester + cache side (drives requests and cache_rdata)
//   slave  - the arbiter (drives grants, responses and cache strobes)
// -----------------------------------------------------------------------------
interface dcache_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_err;

    logic              dma_req;
    logic              dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata;
    logic [LEN_W-1:0]  dma_len;
    logic              dma_gnt;
    logic              dma_rvalid;
    logic [DATA_W-1:0] dma_rdata;
    logic              dma_err;

    logic [ADDR_W-1:0] cache_addr;
    logic              cache_we;
    logic              cache_re;
    logic [DATA_W-1:0] cache_wdata;
    logic [DATA_W-1:0] cache_rdata;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata, cpu_err,
        output dma_req, dma_we, dma_addr, dma_wdata, dma_len,
        input  dma_gnt, dma_rvalid, dma_rdata, dma_err,
        input  cache_addr, cache_we, cache_re, cache_wdata,
        output cache_rdata
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata, cpu_err,
        input  dma_req, dma_we, dma_addr, dma_wdata, dma_len,
        output dma_gnt, dma_rvalid, dma_rdata, dma_err,
        output cache_addr, cache_we, cache_re, cache_wdata,
        input  cache_rdata
    );
endinterface

// File: rtl/dcache_arb_burst_ctr.sv
// -----------------------------------------------------------------------------
// dcache_arb_burst_ctr
// Burst beat counter and CPU starvation counter for the arbiter.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   load/load_val- start a burst with load_val remaining beats
//   dec          - one DMA beat granted inside the burst
//   clr          - burst abandoned
//   in_lock      - arbiter is in DMA_LOCK
//   cpu_req/gnt  - CPU request and grant this cycle
//   beats_left   - remaining beats of the locked burst
//   burst_active - beats_left is non-zero
//   steal        - CPU has waited STARVE_LIMIT cycles; give it this slot
// -----------------------------------------------------------------------------
module dcache_arb_burst_ctr #(
    parameter int LEN_W        = 4,
    parameter int STARVE_LIMIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [LEN_W-1:0] load_val,
    input  logic             dec,
    input  logic             clr,
    input  logic             in_lock,
    input  logic             cpu_req,
    input  logic             cpu_gnt,
    output logic [LEN_W-1:0] beats_left,
    output logic             burst_active,
    output logic             steal
);
    localparam int SC_W = $clog2(STARVE_LIMIT + 1);

    logic [SC_W-1:0] starve_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beats_left <= '0;
        end else if (clr) begin
            beats_left <= '0;
        end else if (load) begin
            beats_left <= load_val;
        end else if (dec && beats_left != '0) begin
            beats_left <= beats_left - LEN_W'(1);
        end
    end

    // Counts cycles the CPU waits behind a locked burst; any cycle the CPU
    // is idle or served restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (!cpu_req || cpu_gnt) begin
            starve_cnt <= '0;
        end else if (in_lock && starve_cnt != SC_W'(STARVE_LIMIT)) begin
            starve_cnt <= starve_cnt + SC_W'(1);
        end
    end

    assign burst_active = (beats_left != '0);
    assign steal        = in_lock & cpu_req & (starve_cnt == SC_W'(STARVE_LIMIT));

endmodule

// File: rtl/dcache_port_arbiter.sv
// -----------------------------------------------------------------------------
// dcache_port_arbiter
// Shares the single-port data cache between the CPU MEM stage (port 0) and a
// DMA/debug loader (port 1). One access is granted per cycle; the winner
// drives the cache combinationally and its read data is registered back one
// cycle later. DMA bursts lock the cache, except that a CPU starved for
// STARVE_LIMIT cycles steals one slot. Word addresses >= DEPTH never strobe
// the cache and return an error response.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   bus        - dcache_port_arbiter_if.slave (requesters + cache)
//   stat_conflict_cnt, stat_steal_cnt - only with DCACHE_ARB_STATS_EN
// Build option:
//   DCACHE_ARB_STATS_EN - adds saturating conflict / steal counters
// -----------------------------------------------------------------------------
module dcache_port_arbiter
    import dcache_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int DEPTH        = 256,
    parameter int MAX_BURST    = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    dcache_port_arbiter_if.slave     bus
`ifdef DCACHE_ARB_STATS_EN
    ,
    output logic [31:0]              stat_conflict_cnt,
    output logic [31:0]              stat_steal_cnt
`endif
);
    localparam int LEN_W = $clog2(MAX_BURST + 1);

    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        if (len == '0) return LEN_W'(1);
        if (len > LEN_W'(MAX_BURST)) return LEN_W'(MAX_BURST);
        return len;
    endfunction

    function automatic resp_t next_resp(input resp_t cur, input logic gnt,
                                        input logic we, input logic inr,
                                        input logic [RESP_DATA_W-1:0] rd);
        resp_t r;
        r       = cur;
        r.valid = gnt & ~we;
        r.err   = gnt & ~inr;
        if (gnt && !we) r.data = inr ? rd : '0;
        return r;
    endfunction

    arb_state_e       state, state_nxt;
    port_id_e         winner;
    logic             gnt_cpu, gnt_dma, grant_any;
    logic             load, dec, clr;
    logic [LEN_W-1:0] eff_len, beats_left;
    logic             burst_active, steal;
    logic             sel_we, in_range;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    resp_t            resp_cpu_p1, resp_dma_p1;

    dcache_arb_burst_ctr #(
        .LEN_W        (LEN_W),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_burst_ctr (
        .clk          (clk),
        .rst_n        (rst_n),
        .load         (load),
        .load_val     (eff_len - LEN_W'(1)),
        .dec          (dec),
        .clr          (clr),
        .in_lock      (state == DMA_LOCK),
        .cpu_req      (bus.cpu_req),
        .cpu_gnt      (gnt_cpu),
        .beats_left   (beats_left),
        .burst_active (burst_active),
        .steal        (steal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ARB;
        else        state <= state_nxt;
    end

    // Grants are gated by rst_n so every output is low while reset is held.
    always_comb begin
        state_nxt = state;
        gnt_cpu   = 1'b0;
        gnt_dma   = 1'b0;
        load      = 1'b0;
        dec       = 1'b0;
        clr       = 1'b0;
        eff_len   = clamp_len(bus.dma_len);
        if (rst_n) begin
            unique case (state)
                ARB: begin
                    if (bus.cpu_req) begin
                        gnt_cpu = 1'b1;
                    end else if (bus.dma_req) begin
                        gnt_dma = 1'b1;
                        if (eff_len > LEN_W'(1)) begin
                            load      = 1'b1;
                            state_nxt = DMA_LOCK;
                        end
                    end
                end
                DMA_LOCK: begin
                    if (!bus.dma_req || !burst_active) begin
                        // Burst abandoned; the slot is not wasted.
                        clr       = 1'b1;
                        state_nxt = ARB;
                        gnt_cpu   = bus.cpu_req;
                    end else if (steal) begin
                        gnt_cpu = 1'b1;
                    end else begin
                        gnt_dma = 1'b1;
                        dec     = 1'b1;
                        if (beats_left == LEN_W'(1)) state_nxt = ARB;
                    end
                end
                default: state_nxt = ARB;
            endcase
        end
    end

    assign grant_any = gnt_cpu | gnt_dma;
    assign winner    = gnt_dma ? PORT_DMA : PORT_CPU;
    assign sel_we    = (winner == PORT_DMA) ? bus.dma_we    : bus.cpu_we;
    assign sel_addr  = (winner == PORT_DMA) ? bus.dma_addr  : bus.cpu_addr;
    assign sel_wdata = (winner == PORT_DMA) ? bus.dma_wdata : bus.cpu_wdata;
    assign in_range  = (sel_addr < ADDR_W'(DEPTH));

    assign bus.cpu_gnt     = gnt_cpu;
    assign bus.dma_gnt     = gnt_dma;
    assign bus.cache_addr  = grant_any ? sel_addr  : '0;
    assign bus.cache_wdata = grant_any ? sel_wdata : '0;
    assign bus.cache_re    = grant_any & ~sel_we & in_range;
    assign bus.cache_we    = grant_any &  sel_we & in_range;

    // ---- stage p1: registered responses ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_cpu_p1 <= '0;
            resp_dma_p1 <= '0;
        end else begin
            resp_cpu_p1 <= next_resp(resp_cpu_p1, gnt_cpu, bus.cpu_we, in_range,
                                     RESP_DATA_W'(bus.cache_rdata));
            resp_dma_p1 <= next_resp(resp_dma_p1, gnt_dma, bus.dma_we, in_range,
                                     RESP_DATA_W'(bus.cache_rdata));
        end
    end

    assign bus.cpu_rvalid = resp_cpu_p1.valid;
    assign bus.cpu_err    = resp_cpu_p1.err;
    assign bus.cpu_rdata  = resp_cpu_p1.data[DATA_W-1:0];
    assign bus.dma_rvalid = resp_dma_p1.valid;
    assign bus.dma_err    = resp_dma_p1.err;
    assign bus.dma_rdata  = resp_dma_p1.data[DATA_W-1:0];

`ifdef DCACHE_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_conflict_cnt <= '0;
            stat_steal_cnt    <= '0;
        end else begin
            if (bus.cpu_req && bus.dma_req && stat_conflict_cnt != '1)
                stat_conflict_cnt <= stat_conflict_cnt + 32'd1;
            if (steal && stat_steal_cnt != '1)
                stat_steal_cnt <= stat_steal_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: doc/dcache_port_arbiter.md
Name: dcache_port_arbiter

Overview:
- Shares the single-port data cache between two requesters: the CPU MEM stage (port 0) and a DMA/debug loader (port 1).
- Grants one access per cycle and drives the cache strobes combinationally.
- Registers read data back to the winner.
- Supports locked DMA bursts, with CPU anti-starvation slot stealing and out-of-range address detection.

Parameters:
- ADDR_W, 32, word-address width of both requesters and the cache.
- DATA_W, 32, data width.
- DEPTH, 256, number of valid cache words; word addresses >= DEPTH are out of range.
- MAX_BURST, 8, maximum DMA burst length in beats.
- STARVE_LIMIT, 4, consecutive ungranted CPU cycles tolerated during a DMA burst.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cpu_req  in  1  CPU access request
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  word address
- cpu_wdata  in  DATA_W  write data
- cpu_gnt  out  1  access accepted this cycle
- cpu_rvalid  out  1  read response valid
- cpu_rdata  out  DATA_W  read data
- cpu_err  out  1  out-of-range response
- dma_req, dma_we, dma_addr, dma_wdata  in  same widths as the CPU equivalents
- dma_len  in  $clog2(MAX_BURST+1)  burst length, sampled on the first beat
- dma_gnt, dma_rvalid, dma_rdata, dma_err  out  same widths as the CPU equivalents
- cache_addr  out  ADDR_W  to dCacheAddr
- cache_we  out  1  to dCacheWriteEn
- cache_re  out  1  to dCacheReadEn
- cache_wdata  out  DATA_W  to dCacheWriteData
- cache_rdata  in  DATA_W  from dCacheReadData (combinational)

Behaviour:
- Reset (asynchronous, rst_n=0):
  - All outputs 0.
  - State ARB; beats_left=0; starve_cnt=0.
  - Reset mid-burst abandons the burst; no response pulses follow.
- Grant timing:
  - Grant is combinational in the request cycle.
  - At most one gnt is high per cycle.
  - The winner's address, write data and we drive the cache in the same cycle.
  - cache_re = grant & ~we & in_range; cache_we = grant & we & in_range.
  - With no grant: cache_re=0, cache_we=0, cache_addr=0.
- Response, registered one cycle after the grant:
  - Read: <port>_rvalid=1 and <port>_rdata=cache_rdata captured in the grant cycle.
  - Write: no rvalid.
  - <port>_err pulses for any out-of-range grant (read or write). An out-of-range read returns rvalid=1, rdata=0. Out-of-range accesses never strobe the cache.
  - rdata holds its value until the next read response.
- State ARB:
  - cpu_req wins (fixed CPU priority).
  - Otherwise dma_req is granted, with eff_len = clamp(dma_len, 1, MAX_BURST); dma_len=0 is treated as 1.
  - If eff_len>1, load beats_left=eff_len-1 and go to DMA_LOCK.
- State DMA_LOCK:
  - DMA is granted each cycle dma_req=1; beats_left decrements per DMA grant.
  - beats_left reaching 0 -> ARB.
  - dma_req=0 in DMA_LOCK -> burst abandoned, go to ARB, beats_left=0.
- Starvation:
  - In DMA_LOCK, starve_cnt increments each cycle cpu_req=1 and the CPU is not granted.
  - When starve_cnt==STARVE_LIMIT, the CPU is granted that cycle instead of DMA (steal). starve_cnt clears; beats_left is unchanged; state stays DMA_LOCK.
  - starve_cnt clears whenever cpu_req=0 or the CPU is granted.
- Simultaneous requests in ARB: CPU granted, DMA waits; no burst starts.
- Back-to-back grants are allowed every cycle; responses pipeline one per cycle.

Optional Feature:
- DCACHE_ARB_STATS_EN defined:
  - Adds outputs stat_conflict_cnt[31:0] (cycles with both req=1) and stat_steal_cnt[31:0] (steal events).
  - Both are saturating and reset to 0.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package dcache_arb_pkg holds:
  - arb_state_e {ARB, DMA_LOCK}
  - port_id_e {PORT_CPU, PORT_DMA}
  - response struct {valid, err, data}
- Sub-module dcache_arb_burst_ctr: beats_left load/decrement/clear plus the starve_cnt counter, with outputs burst_active and steal.

Test Plan:
- Reset, then CPU write addr 5 data 0xDEADBEEF, then CPU read addr 5 -> cache_we pulse in cycle 1; cpu_rvalid=1, cpu_rdata=0xDEADBEEF one cycle after the read grant.
- CPU and DMA requesting simultaneously in ARB, dma_len=1 -> cpu_gnt=1, dma_gnt=0; DMA granted the first cycle cpu_req drops.
- DMA burst dma_len=4 with CPU idle -> 4 consecutive dma_gnt; state returns to ARB after beat 4; 4 dma_rvalid pulses for reads.
- DMA burst dma_len=8 with cpu_req held from beat 2 and STARVE_LIMIT=4 -> CPU granted after 4 waited cycles; DMA resumes and still completes 8 beats total.
- CPU read addr 300 (DEPTH=256) -> cache_re=0; next cycle cpu_rvalid=1, cpu_err=1, cpu_rdata=0.
- rst_n asserted during DMA_LOCK with beats_left=3 -> all outputs 0 immediately; after release, a CPU request is granted the first cycle.
